// File: rtl/run_ctrl_if.sv
// Bus between the run controller and the test harness / fetch unit.
// Master drives the request side; slave (run_ctrl) drives status.
interface run_ctrl_if #(
    parameter int CW = 16
);
    logic          Req;
    logic          Halt_instr;
    logic [CW-1:0] PC;
    logic [CW-1:0] Max_cycles;
    logic          Init;
    logic          Halt;
    logic          Ack;
    logic          Timeout;
    logic [CW-1:0] Cycle_count;
    logic [CW-1:0] Last_pc;

    modport master (
        output Req, Halt_instr, PC, Max_cycles,
        input  Init, Halt, Ack, Timeout, Cycle_count, Last_pc
    );

    modport slave (
        input  Req, Halt_instr, PC, Max_cycles,
        output Init, Halt, Ack, Timeout, Cycle_count, Last_pc
    );
endinterface

// File: rtl/run_ctrl.sv
// Run sequencer: pulses Init, releases Halt for one bounded run,
// then holds Ack until the requester drops Req.
module run_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int CW          = 16
) (
    input logic        CLK,
    input logic        Reset,
    run_ctrl_if.slave  bus
);
    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [ICW-1:0] init_cnt_q, init_cnt_d;
    logic [CW-1:0]  cycle_count_q, cycle_count_d;
    logic [CW-1:0]  last_pc_q, last_pc_d;
    logic           timeout_q, timeout_d;
    logic [CW:0]    count_next;
    logic           limit_hit;
    logic           run_end;

    // One extra bit so a saturated counter never aliases a limit match.
    assign count_next = {1'b0, cycle_count_q} + (CW+1)'(1);
    assign limit_hit  = (bus.Max_cycles != '0)
                      && (count_next == {1'b0, bus.Max_cycles});
    assign run_end    = bus.Halt_instr || limit_hit;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= IDLE;
            init_cnt_q    <= '0;
            cycle_count_q <= '0;
            last_pc_q     <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            cycle_count_q <= cycle_count_d;
            last_pc_q     <= last_pc_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.Req) state_d = INIT;
            INIT:    if (init_cnt_q == INIT_LAST) state_d = RUN;
            RUN:     if (run_end) state_d = DONE;
            DONE:    if (!bus.Req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        init_cnt_d    = '0;
        cycle_count_d = cycle_count_q;
        last_pc_d     = last_pc_q;
        timeout_d     = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    cycle_count_d = '0;
                    last_pc_d     = '0;
                    timeout_d     = 1'b0;
                end
            end
            INIT: begin
                if (init_cnt_q != INIT_LAST)
                    init_cnt_d = init_cnt_q + ICW'(1);
            end
            RUN: begin
                if (!count_next[CW])
                    cycle_count_d = count_next[CW-1:0];
                if (run_end) begin
                    last_pc_d = bus.PC;
                    timeout_d = !bus.Halt_instr;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.Init = (state_q == INIT);
        bus.Halt = (state_q != RUN);
        bus.Ack  = (state_q == DONE);
    end

    assign bus.Timeout     = timeout_q;
    assign bus.Cycle_count = cycle_count_q;
    assign bus.Last_pc     = last_pc_q;
endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed runs checked against a phase-level
// model every cycle, plus literal checks at key points.
module tb_run_ctrl;
    localparam int CW   = 16;
    localparam int INIT = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 0;

    run_ctrl_if #(.CW(CW)) bus ();

    run_ctrl #(.INIT_CYCLES(INIT), .CW(CW)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: cycles of Init left, running / finished flags, counters.
    int m_init_left = 0;
    bit m_run = 0;
    bit m_done = 0;
    int m_cnt = 0;
    bit m_to = 0;
    int m_last = 0;

    always @(posedge CLK) begin : mdl
        int il, cnt, last;
        bit run, done, to, stop;
        il = m_init_left; run = m_run; done = m_done;
        cnt = m_cnt; to = m_to; last = m_last;
        if (Reset) begin
            il = 0; run = 0; done = 0; cnt = 0; to = 0; last = 0;
        end else if (done) begin
            if (!bus.Req) done = 0;
        end else if (run) begin
            stop = bus.Halt_instr
                || (bus.Max_cycles != 0 && cnt + 1 == int'(bus.Max_cycles));
            if (stop) begin
                run = 0; done = 1;
                to = !bus.Halt_instr;
                last = int'(bus.PC);
            end
            cnt = (cnt >= CMAX) ? CMAX : cnt + 1;
        end else if (il > 0) begin
            il = il - 1;
            if (il == 0) run = 1;
        end else if (bus.Req) begin
            il = INIT; cnt = 0; to = 0; last = 0;
        end
        m_init_left <= il; m_run <= run; m_done <= done;
        m_cnt <= cnt; m_to <= to; m_last <= last;
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            n_checks++;
            if (bus.Init !== (m_init_left > 0) || bus.Halt !== !m_run
                || bus.Ack !== m_done || bus.Timeout !== m_to
                || bus.Cycle_count !== CW'(m_cnt)
                || bus.Last_pc !== CW'(m_last)) begin
                n_errors++;
                $display("FAIL cycle_model t=%0t got i%b h%b a%b t%b c%h l%h exp i%b h%b a%b t%b c%h l%h",
                         $time, bus.Init, bus.Halt, bus.Ack, bus.Timeout,
                         bus.Cycle_count, bus.Last_pc, m_init_left > 0,
                         !m_run, m_done, m_to, CW'(m_cnt), CW'(m_last));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise Req and run until Ack; PC = run index - 1.
    task automatic run_prog(input int halt_at, input int lim,
                            input int chg_at, input int chg_val,
                            output int n_init, output int n_run);
        bit ok;
        ok = 0; n_init = 0; n_run = 0;
        bus.Max_cycles = CW'(lim);
        bus.Req = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (bus.Ack) begin ok = 1; break; end
            if (bus.Init) n_init++;
            if (!bus.Halt) begin
                n_run++;
                bus.PC = CW'(n_run - 1);
                bus.Halt_instr = (n_run == halt_at);
                if (n_run == chg_at) bus.Max_cycles = CW'(chg_val);
            end else begin
                bus.Halt_instr = 1'b0;
            end
        end
        bus.Halt_instr = 1'b0;
        check("ack_reached", 32'(ok), 1);
    endtask

    initial begin
        int ni, nr;
        Reset = 1'b1;
        bus.Req = 1'b0;
        bus.Halt_instr = 1'b0;
        bus.PC = '0;
        bus.Max_cycles = '0;
        @(posedge CLK);
        #1 chk_en = 1;
        @(negedge CLK);
        check("rst_init", 32'(bus.Init), 0);
        check("rst_halt", 32'(bus.Halt), 1);
        check("rst_ack", 32'(bus.Ack), 0);
        check("rst_to", 32'(bus.Timeout), 0);
        check("rst_cnt", 32'(bus.Cycle_count), 0);
        check("rst_last", 32'(bus.Last_pc), 0);
        Reset = 1'b0;

        run_prog(5, 0, 0, 0, ni, nr);
        check("t1_init_cycles", 32'(ni), 2);
        check("t1_run_cycles", 32'(nr), 5);
        check("t1_cnt", 32'(bus.Cycle_count), 5);
        check("t1_last", 32'(bus.Last_pc), 4);
        check("t1_to", 32'(bus.Timeout), 0);
        bus.Req = 1'b0;
        @(negedge CLK);
        check("t1_ack_drop", 32'(bus.Ack), 0);
        bus.Halt_instr = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_halt_instr", 32'(bus.Halt), 1);
        bus.Halt_instr = 1'b0;

        run_prog(0, 10, 0, 0, ni, nr);
        check("t2_run_cycles", 32'(nr), 10);
        check("t2_to", 32'(bus.Timeout), 1);
        check("t2_cnt", 32'(bus.Cycle_count), 10);
        check("t2_last", 32'(bus.Last_pc), 9);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("hold_ack", 32'(bus.Ack), 1);
        end
        check("hold_cnt", 32'(bus.Cycle_count), 10);
        bus.Req = 1'b0;
        @(negedge CLK);
        check("hs_ack_low", 32'(bus.Ack), 0);
        check("hs_to_held", 32'(bus.Timeout), 1);
        bus.Req = 1'b1;
        @(negedge CLK);
        check("reinit_init", 32'(bus.Init), 1);
        check("reinit_to", 32'(bus.Timeout), 0);
        check("reinit_cnt", 32'(bus.Cycle_count), 0);

        run_prog(3, 3, 0, 0, ni, nr);
        check("t3_run_cycles", 32'(nr), 3);
        check("t3_to", 32'(bus.Timeout), 0);
        check("t3_cnt", 32'(bus.Cycle_count), 3);
        check("t3_last", 32'(bus.Last_pc), 2);

        bus.Req = 1'b0;
        @(negedge CLK);
        bus.Req = 1'b1;
        bus.Max_cycles = '0;
        nr = 0;
        for (int c = 0; c < 20 && nr < 4; c++) begin
            @(negedge CLK);
            if (!bus.Halt) nr++;
        end
        check("t4_reached_run4", 32'(nr), 4);
        Reset = 1'b1;
        @(negedge CLK);
        check("t4_halt", 32'(bus.Halt), 1);
        check("t4_ack", 32'(bus.Ack), 0);
        check("t4_cnt", 32'(bus.Cycle_count), 0);
        Reset = 1'b0;
        @(negedge CLK);
        check("t4_reinit", 32'(bus.Init), 1);
        run_prog(2, 0, 0, 0, ni, nr);
        check("t4_cnt_end", 32'(bus.Cycle_count), 2);

        bus.Req = 1'b0;
        @(negedge CLK);
        run_prog(0, 0, 2, 4, ni, nr);
        check("t6_run_cycles", 32'(nr), 4);
        check("t6_to", 32'(bus.Timeout), 1);
        check("t6_last", 32'(bus.Last_pc), 3);

        bus.Req = 1'b0;
        @(negedge CLK);
        bus.Req = 1'b1;
        bus.Max_cycles = '0;
        repeat (70000) @(negedge CLK);
        check("sat_cnt", 32'(bus.Cycle_count), 32'hFFFF);
        check("sat_running", 32'(bus.Halt), 0);
        check("sat_ack", 32'(bus.Ack), 0);
        Reset = 1'b1;
        @(negedge CLK);
        check("final_rst_cnt", 32'(bus.Cycle_count), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 2, number of consecutive cycles Init is held high per start.
REQ-002 Parameter CW, default 16, width of PC, cycle counter and cycle limit.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK only.
REQ-004 Reset  input  1  reset, synchronous and active-high.
REQ-005 Req  input  1  start request from the test bench; level, 4-phase handshake with Ack.
REQ-006 Halt_instr  input  1  decoder flag: the instruction at the current PC is the halt opcode.
REQ-007 PC  input  CW  program counter from the fetch unit.
REQ-008 Max_cycles  input  CW  RUN cycle limit; 0 = unlimited.
REQ-009 Init  output  1  drives the fetch unit Init (PC <= 0).
REQ-010 Halt  output  1  drives the fetch unit Halt (freeze PC).
REQ-011 Ack  output  1  program finished; handshake acknowledge.
REQ-012 Timeout  output  1  last run ended by the cycle limit, not by Halt_instr.
REQ-013 Cycle_count  output  CW  RUN cycles elapsed in the current or last run.
REQ-014 Last_pc  output  CW  PC value sampled in the final RUN cycle.

Function
REQ-015 FSM states IDLE, INIT, RUN, DONE; Moore outputs: Init=1 only in INIT; Halt=1 in IDLE, INIT, DONE; Halt=0 only in RUN; Ack=1 only in DONE.
REQ-016 IDLE -> INIT when Req=1 at a posedge; otherwise stay in IDLE.
REQ-017 INIT lasts exactly INIT_CYCLES cycles (internal counter), then -> RUN.
REQ-018 On entry to INIT: Cycle_count <= 0, Timeout <= 0, Last_pc <= 0.
REQ-019 In RUN, Cycle_count increments by 1 per cycle, saturating at all-ones (no wrap).
REQ-020 RUN -> DONE when Halt_instr=1; Last_pc <= PC in the same edge; Timeout stays 0.
REQ-021 RUN -> DONE when Max_cycles != 0 and Cycle_count+1 == Max_cycles at that edge (i.e. exactly Max_cycles RUN cycles); Timeout <= 1, Last_pc <= PC.
REQ-022 Halt_instr and limit reached in the same cycle: halt wins, Timeout=0.
REQ-023 Req changes during INIT or RUN are ignored.
REQ-024 DONE holds Ack=1 and Halt=1 until Req=0 at a posedge, then -> IDLE; Cycle_count, Timeout and Last_pc hold in DONE and IDLE until the next INIT entry.
REQ-025 Req still high on return to IDLE starts a new run on the next edge (no lockout beyond the DONE->IDLE cycle).
REQ-026 Max_cycles is sampled every RUN cycle; changing it mid-run takes effect immediately.
REQ-027 Halt_instr outside RUN has no effect.

Reset
REQ-028 Reset=1 at a posedge forces state IDLE from any state, including mid-INIT and mid-RUN.
REQ-029 Reset values: Init=0, Halt=1, Ack=0, Timeout=0, Cycle_count=0, Last_pc=0, INIT counter=0.
REQ-030 Reset takes priority over Req, Halt_instr and the cycle limit in the same cycle.

Verification
REQ-031 Reset, Req=1 held, Max_cycles=0, Halt_instr at 5th RUN cycle with PC=0x0004 -> Init high exactly 2 cycles, Halt low 5 cycles, Ack=1, Cycle_count=5, Last_pc=0x0004, Timeout=0.
REQ-032 Max_cycles=10, Halt_instr never -> DONE after exactly 10 RUN cycles, Timeout=1, Cycle_count=10.
REQ-033 Max_cycles=3, Halt_instr asserted in 3rd RUN cycle -> Timeout=0, Cycle_count=3.
REQ-034 Reset asserted in 4th RUN cycle -> next cycle IDLE, Halt=1, Ack=0, Cycle_count=0; Req still high -> INIT on the following edge.
REQ-035 Ack handshake: keep Req high 6 cycles after Ack -> Ack stays 1 and outputs frozen; drop Req -> Ack=0 next cycle; re-raise Req -> new run clears Cycle_count and Timeout on INIT entry.
REQ-036 Max_cycles=0, no Halt_instr for 70000 cycles -> Cycle_count saturates at 0xFFFF, state stays RUN.
